cal_filter: RTL

Averaging and lock-detect stage that consumes the 6-bit tap-count measurement `d` from the carry-chain delay calibration block. It samples `d` once per 128-cycle measurement frame and discards out-of-range samples. It averages 2^LOG2N accepted samples into a fixed-point tap count and asserts `locked` once successive averages agree, so downstream TDC decode logic has a stable taps-per-period value.

---
 rtl/cal_filter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/cal_filter.sv
// cal_filter: frame-strobed averaging and lock detection for the carry-chain
// tap-count measurement. One sample per 128-cycle frame, out-of-range samples
// are counted and dropped, 2^LOG2N accepted samples form one fixed-point average.
`timescale 1ns/1ps
module cal_filter #(
  parameter int unsigned LOG2N    = 4,
  parameter int unsigned MIN_TAPS = 8,
  parameter int unsigned MAX_TAPS = 60,
  parameter int unsigned LOCK_TOL = 16,
  parameter int unsigned LOCK_CNT = 4
) (
  input  logic                 c,
  input  logic                 rst_n,
  input  logic [5:0]           d,
  input  logic                 en,
  output logic [6+LOG2N-1:0]   avg,
  output logic                 avg_valid,
  output logic                 locked,
  output logic [7:0]           rejects
);

  localparam int unsigned SW = 6 + LOG2N;
  localparam int unsigned CW = LOG2N + 1;
  localparam int unsigned MW = 4;
  localparam int unsigned PW = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_ph;
  logic [SW-1:0]   r_sum;
  logic [CW-1:0]   r_cnt;
  logic [MW-1:0]   r_match;
  logic            r_have_prev;
  logic [SW-1:0]   r_avg;
  logic            r_avg_valid;
  logic            r_locked;
  logic [7:0]      r_rejects;

  logic            w_strobe;
  logic            w_in_range;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_cnt_full;
  logic [SW-1:0]   w_diff;
  logic [MW-1:0]   w_match_nxt;

  // Strobe decode, range check and lock-match arithmetic for the current cycle
  always_comb begin
    w_strobe    = (r_state == ACQ) && (r_ph == PW'(127));
    w_in_range  = (d >= 6'(MIN_TAPS)) && (d <= 6'(MAX_TAPS));
    w_cnt_inc   = r_cnt + CW'(1);
    w_cnt_full  = (w_cnt_inc == CW'(1 << LOG2N));
    // Unsigned distance between new sum and previous average, larger minus smaller
    w_diff      = (r_sum >= r_avg) ? (r_sum - r_avg) : (r_avg - r_sum);
    w_match_nxt = '0;
    if (r_have_prev && (w_diff <= SW'(LOCK_TOL))) begin
      if (r_match == MW'(LOCK_CNT)) begin
        w_match_nxt = r_match;
      end else begin
        w_match_nxt = r_match + MW'(1);
      end
    end
  end

  // Control FSM with frame counter, accumulator, lock tracker and registered outputs
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ph        <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_match     <= '0;
      r_have_prev <= 1'b0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
      r_locked    <= 1'b0;
      r_rejects   <= '0;
    end else begin
      r_avg_valid <= 1'b0;
      if (!en) begin
        // Idle drops any partial average and forgets lock history
        r_state     <= IDLE;
        r_ph        <= '0;
        r_sum       <= '0;
        r_cnt       <= '0;
        r_match     <= '0;
        r_have_prev <= 1'b0;
        r_locked    <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= ACQ;
          end
          ACQ: begin
            r_ph <= r_ph + PW'(1);
            if (w_strobe) begin
              if (w_in_range) begin
                r_sum <= r_sum + SW'(d);
                r_cnt <= w_cnt_inc;
                if (w_cnt_full) begin
                  r_state <= OUT;
                end
              end else if (r_rejects != 8'hFF) begin
                r_rejects <= r_rejects + 8'd1;
              end
            end
          end
          OUT: begin
            r_ph        <= r_ph + PW'(1);
            r_avg       <= r_sum;
            r_avg_valid <= 1'b1;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_have_prev <= 1'b1;
            r_match     <= w_match_nxt;
            r_locked    <= (w_match_nxt == MW'(LOCK_CNT));
            r_state     <= ACQ;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign avg       = r_avg;
  assign avg_valid = r_avg_valid;
  assign locked    = r_locked;
  assign rejects   = r_rejects;

endmodule
